// File: rtl/seq_fsm_pkg.sv
// Shared types and helpers for the parametrised sequencing FSM.
// Holds the status encoding, the step function and the dwell-width sizing.
package seq_fsm_pkg;

  typedef enum logic [1:0] {RUN, DONE, FAULT} status_t;

  typedef struct packed {
    logic [31:0] idx;
    logic        wrapped;
  } step_t;

  // At the last state a step either wraps to 0 or stays put.
  function automatic step_t next_state(input logic [31:0] idx,
                                       input logic [31:0] num_states,
                                       input logic        wrap);
    step_t s;
    s.idx     = idx + 32'd1;
    s.wrapped = 1'b0;
    if (idx == num_states - 32'd1) begin
      s.idx     = wrap ? '0 : idx;
      s.wrapped = wrap;
    end
    return s;
  endfunction

  function automatic int unsigned dwell_max(input int unsigned min_dwell,
                                            input int unsigned timeout);
    return (min_dwell > timeout) ? min_dwell : timeout;
  endfunction

  function automatic int unsigned dwell_width(input int unsigned min_dwell,
                                              input int unsigned timeout);
    int unsigned m;
    m = dwell_max(min_dwell, timeout);
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_fsm_n_dwell_counter.sv
// Saturating per-state dwell counter with minimum-dwell and timeout decodes.
module seq_dwell_counter
  import seq_fsm_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 0,
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned W         = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic min_met,
  output logic timeout_hit
);

  localparam logic [W-1:0] SAT = W'(dwell_max(MIN_DWELL, TIMEOUT));

  logic [W-1:0] dwell;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      dwell <= '0;
    end else if (inc && dwell != SAT) begin
      dwell <= dwell + 1'b1;
    end
  end

  // Zero-valued thresholds are resolved at elaboration to keep compares meaningful.
  if (MIN_DWELL == 0) begin : g_no_min
    assign min_met = 1'b1;
  end else begin : g_min
    assign min_met = (dwell >= W'(MIN_DWELL));
  end

  if (TIMEOUT == 0) begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end else begin : g_timeout
    assign timeout_hit = (dwell == W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/seq_fsm_n.sv
// Parametrised sequencer: steps through NUM_STATES states on cond[state],
// with minimum dwell, timeout fault, wrap/stop mode and saturating lap count.
module seq_fsm_n
  import seq_fsm_pkg::*;
#(
  parameter int NUM_STATES = 5,
  parameter int STATE_W    = $clog2(NUM_STATES),
  parameter int MIN_DWELL  = 0,
  parameter int TIMEOUT    = 0,
  parameter int LAP_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  wrap_en,
  input  logic [NUM_STATES-1:0] cond,
  output logic [STATE_W-1:0]    y,
  output logic [NUM_STATES-1:0] y_onehot,
  output logic                  advance,
  output logic                  done,
  output logic                  fault,
  output logic [LAP_W-1:0]      lap_count
);

  localparam int unsigned DWELL_W = dwell_width(MIN_DWELL, TIMEOUT);

  status_t               status, status_next;
  logic [STATE_W-1:0]    y_next;
  logic                  advance_next, done_next, fault_next;
  logic [LAP_W-1:0]      lap_next;
  logic                  dwell_clr, dwell_inc;
  logic                  min_met, timeout_hit;
  step_t                 step;

  seq_dwell_counter #(
    .MIN_DWELL (MIN_DWELL),
    .TIMEOUT   (TIMEOUT),
    .W         (DWELL_W)
  ) u_dwell (
    .clock       (clock),
    .reset       (reset),
    .clear       (dwell_clr),
    .inc         (dwell_inc),
    .min_met     (min_met),
    .timeout_hit (timeout_hit)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      status    <= RUN;
      y         <= '0;
      y_onehot  <= NUM_STATES'(1);
      advance   <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      lap_count <= '0;
    end else begin
      status    <= status_next;
      y         <= y_next;
      y_onehot  <= NUM_STATES'(1) << y_next;
      advance   <= advance_next;
      done      <= done_next;
      fault     <= fault_next;
      lap_count <= lap_next;
    end
  end

  always_comb begin
    status_next  = status;
    y_next       = y;
    advance_next = 1'b0;
    done_next    = done;
    fault_next   = fault;
    lap_next     = lap_count;
    dwell_clr    = 1'b0;
    dwell_inc    = 1'b0;
    step         = next_state(32'(y), 32'(NUM_STATES), wrap_en);

    if (clear) begin
      status_next = RUN;
      y_next      = '0;
      done_next   = 1'b0;
      fault_next  = 1'b0;
      lap_next    = '0;
      dwell_clr   = 1'b1;
    end else if (status == RUN && en) begin
      // Advance takes precedence over a timeout due in the same cycle.
      if (cond[y] && min_met) begin
        advance_next = 1'b1;
        dwell_clr    = 1'b1;
        if (32'(y) == 32'(NUM_STATES - 1) && !wrap_en) begin
          done_next   = 1'b1;
          status_next = DONE;
        end else begin
          y_next = STATE_W'(step.idx);
          if (step.wrapped && lap_count != '1) begin
            lap_next = lap_count + 1'b1;
          end
        end
      end else if (timeout_hit) begin
        fault_next  = 1'b1;
        status_next = FAULT;
      end else begin
        dwell_inc = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_fsm_n.sv
// Directed bench for seq_fsm_n: three instances cover wrap/stop and en-hold
// (defaults), minimum dwell (MIN_DWELL=3) and dwell timeout (TIMEOUT=6).
module tb_seq_fsm_n;

  logic       clock = 1'b0;
  logic       reset, en, clear, wrap_en;
  logic [4:0] cond_all, cond_c;

  logic [2:0] a_y, b_y, c_y;
  logic [4:0] a_oh, b_oh, c_oh;
  logic       a_adv, b_adv, c_adv;
  logic       a_done, b_done, c_done;
  logic       a_fault, b_fault, c_fault;
  logic [7:0] a_lap, b_lap, c_lap;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  seq_fsm_n #(.NUM_STATES(5), .MIN_DWELL(0), .TIMEOUT(0), .LAP_W(8)) dut_a (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .wrap_en(wrap_en),
    .cond(cond_all), .y(a_y), .y_onehot(a_oh), .advance(a_adv),
    .done(a_done), .fault(a_fault), .lap_count(a_lap));

  seq_fsm_n #(.NUM_STATES(5), .MIN_DWELL(3), .TIMEOUT(0), .LAP_W(8)) dut_b (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .wrap_en(wrap_en),
    .cond(cond_all), .y(b_y), .y_onehot(b_oh), .advance(b_adv),
    .done(b_done), .fault(b_fault), .lap_count(b_lap));

  seq_fsm_n #(.NUM_STATES(5), .MIN_DWELL(0), .TIMEOUT(6), .LAP_W(8)) dut_c (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .wrap_en(wrap_en),
    .cond(cond_c), .y(c_y), .y_onehot(c_oh), .advance(c_adv),
    .done(c_done), .fault(c_fault), .lap_count(c_lap));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string tag, input int y, input int adv, input int lap, input int dn);
    logic [4:0] oh;
    oh = 5'b00001 << y;
    check({tag, ".y"},    32'(a_y),   32'(y));
    check({tag, ".oh"},   32'(a_oh),  32'(oh));
    check({tag, ".adv"},  32'(a_adv), 32'(adv));
    check({tag, ".lap"},  32'(a_lap), 32'(lap));
    check({tag, ".done"}, 32'(a_done), 32'(dn));
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b1;
    clear    = 1'b0;
    wrap_en  = 1'b1;
    cond_all = 5'b11111;
    cond_c   = 5'b11011;

    tick();
    tick();
    check_a("reset", 0, 0, 0, 0);
    check("reset.fault", 32'(a_fault), 32'd0);
    check("reset_c.fault", 32'(c_fault), 32'd0);
    check("reset_b.y", 32'(b_y), 32'd0);

    // Free run with wrap: one state per cycle, lap counts each return to 0.
    reset = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_a($sformatf("run%0d", k), k % 5, 1, k / 5, 0);
    end

    // en low at y=1: everything holds, no pulses.
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_a($sformatf("hold%0d", k), 1, 0, 2, 0);
    end
    en = 1'b1;
    tick();
    check_a("resume", 2, 1, 2, 0);
    tick();
    check_a("pre_rst", 3, 1, 2, 0);

    // Mid-run reset.
    reset = 1'b0;
    tick();
    check_a("midrst", 0, 0, 0, 0);
    check("midrst.fault", 32'(a_fault), 32'd0);

    // Stop mode: done the cycle after the last-state advance, then hold.
    reset   = 1'b1;
    wrap_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_a($sformatf("stop%0d", k), k, 1, 0, 0);
    end
    tick();
    check_a("last_adv", 4, 1, 0, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_a($sformatf("donehold%0d", k), 4, 0, 0, 1);
    end
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    wrap_en = 1'b1;
    check_a("clear", 0, 0, 0, 0);
    check("clear_b.y", 32'(b_y), 32'd0);
    check("clear_c.y", 32'(c_y), 32'd0);
    check("clear_c.fault", 32'(c_fault), 32'd0);

    // MIN_DWELL=3 instance advances every 4th edge; TIMEOUT=6 instance
    // enters state 2 at t=2 and faults exactly 6 edges later.
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t <= 12) begin
        check($sformatf("dwell%0d.y", t),   32'(b_y),   32'(t / 4));
        check($sformatf("dwell%0d.adv", t), 32'(b_adv), 32'((t % 4) == 0));
      end
      check($sformatf("tmo%0d.y", t),     32'(c_y),     32'((t >= 2) ? 2 : t));
      check($sformatf("tmo%0d.adv", t),   32'(c_adv),   32'(t <= 2));
      check($sformatf("tmo%0d.fault", t), 32'(c_fault), 32'(t >= 8));
    end
    check("tmo.oh", 32'(c_oh), 32'd4);
    check("tmo.done", 32'(c_done), 32'd0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("tmo_clr.y", 32'(c_y), 32'd0);
    check("tmo_clr.fault", 32'(c_fault), 32'd0);
    tick();
    check("tmo_clr.run", 32'(c_y), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_fsm_n.md
Name: seq_fsm_n

Overview:
- Parametrised sequencing FSM. It steps through NUM_STATES states in order. It advances from state k when condition input cond[k] is high and the minimum dwell time has elapsed.
- Generalises the fixed five-state sequencer by adding:
  - configurable state count;
  - minimum dwell per state;
  - dwell timeout fault;
  - wrap/stop mode;
  - lap counting.
- Sits in the regression designs as the next-generation control FSM, driven directly by simulation test wrappers.

Parameters:
- NUM_STATES, 5, number of sequence states; legal range 2..256.
- STATE_W, $clog2(NUM_STATES), width of encoded state output (derived; not overridden).
- MIN_DWELL, 0, cycles a state must be held before it may advance; 0 = advance on the first cycle cond is high.
- TIMEOUT, 0, dwell cycles without advancing before a fault; 0 = timeout disabled; must be > MIN_DWELL when nonzero.
- LAP_W, 8, width of lap counter.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  global step enable; when low, state, dwell and outputs hold (pulses deassert).
- clear  in  1  synchronous restart to state 0; clears done, fault and lap_count.
- wrap_en  in  1  1 = state NUM_STATES-1 advances to 0; 0 = stop at last state.
- cond  in  NUM_STATES  per-state advance condition; only cond[state] is examined.
- y  out  STATE_W  current state index.
- y_onehot  out  NUM_STATES  one-hot of y.
- advance  out  1  one-cycle pulse, high in the cycle y shows a newly entered state.
- done  out  1  sticky; set when the last state is exited with wrap_en=0.
- fault  out  1  sticky; set on dwell timeout.
- lap_count  out  LAP_W  count of wraps NUM_STATES-1 -> 0; saturates at all-ones.

Behaviour:
- Reset (reset==0 at posedge):
  - y=0, y_onehot=1, dwell=0;
  - advance=0, done=0, fault=0, lap_count=0.
- Priority per cycle: reset > clear > fault hold > en==0 hold > advance evaluation.
- clear: same register values as reset. Takes effect next edge regardless of en.
- Status machine (shared enum): RUN, DONE, FAULT.
  - RUN -> DONE: last state advances with wrap_en=0.
  - RUN -> FAULT: timeout.
  - DONE/FAULT -> RUN: only via clear or reset.
- Dwell counter:
  - zeroed on state entry;
  - increments each en cycle in RUN when no advance occurs;
  - saturates at max(MIN_DWELL, TIMEOUT).
- Advance condition (RUN, en=1): cond[y]==1 and dwell>=MIN_DWELL.
  - Next edge: y <= y+1, or 0 if y==NUM_STATES-1 and wrap_en=1. Advance=1 for that one cycle.
  - Latency: condition at edge n -> new y visible after edge n, i.e. one clock.
  - With MIN_DWELL=0 and cond all-ones, y increments every cycle.
- Last state with wrap_en=0 and advance condition true:
  - y stays NUM_STATES-1; done<=1; advance<=1 for one cycle.
  - FSM then holds in DONE; advance stays 0 thereafter.
- Wrap: lap_count increments on the same edge y returns to 0. At all-ones it holds (no roll-over).
- Timeout (TIMEOUT>0): RUN, en=1, no advance and dwell==TIMEOUT-1.
  - Next edge: fault<=1, status FAULT; y frozen at the offending state.
  - If advance and timeout are due in the same cycle, advance wins.
- en low: dwell does not count; timeout cannot fire.
- wrap_en is sampled only at the last-state advance edge. Changing it mid-sequence is legal.
- Unused cond bits are ignored.
- y_onehot is always consistent with y. All outputs are registered.

Decomposition:
- Package seq_fsm_pkg:
  - status_t enum {RUN, DONE, FAULT};
  - function next_state(idx, wrap) returning index and wrap flag;
  - localparam computation for dwell counter width.
- Sub-module seq_dwell_counter (saturating, clear-on-entry, enable). Outputs min_met and timeout_hit.

Test Plan:
- NUM_STATES=5, MIN_DWELL=0, cond=5'b11111, wrap_en=1, en=1, release reset -> y=0,1,2,3,4,0,1,... one per cycle; advance=1 each cycle; lap_count=1 on the cycle y returns to 0, then 2 five cycles later.
- As above, wrap_en=0 -> y reaches 4, done=1 the cycle after the last advance; y holds 4 and advance=0 for 10 further cycles; clear=1 one cycle -> y=0, done=0.
- MIN_DWELL=3, cond all-ones -> each state lasts 4 cycles (y changes every 4th edge); advance pulses spaced 4 apart.
- TIMEOUT=6, cond=5'b11011 -> stalls at y=2; fault=1 exactly 6 cycles after entering state 2; y stays 2 until clear.
- Toggle en low for 3 cycles mid-sequence at y=1 -> y, dwell and lap_count frozen, advance=0; sequence resumes unchanged when en returns high.
- Assert reset mid-run at y=3, lap_count=2 -> next cycle y=0, lap_count=0, done=0, fault=0.
